// File: rtl/fuzzy_speed_ctrl_param.sv
// Fuzzy-logic speed controller: periodic sample, 8-grade fuzzification, 15 min-rules, 5-set
// max aggregation and centroid via a restoring divider. Define FUZZY_SLEW_LIMIT_EN to slew-limit pw.
module fuzzy_speed_ctrl_param #(
    parameter int W          = 8,
    parameter int PERIOD_CYC = 25000000,
    parameter int RAMP_LOG2  = 5,
    parameter int E_ZH       = 10,
    parameter int E_SP       = 23,
    parameter int DE_ZH      = 5,
    parameter int C_STOP     = 119,
    parameter int C_SLOW     = 153,
    parameter int C_MED      = 187,
    parameter int C_FAST     = 221,
    parameter int C_BLAST    = 255,
    parameter int MAX_STEP   = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         go,
    input  logic [W-1:0] R,
    input  logic [W-1:0] C,
    output logic [W-1:0] pw,
    output logic         busy,
    output logic         done
);
    localparam int S       = W - RAMP_LOG2;
    localparam int NW      = 2 * W + 3;
    localparam int DW      = W + 3;
    localparam int CW      = $clog2(PERIOD_CYC + 1);
    localparam int KW      = (W > 2) ? $clog2(W) : 1;
    localparam int E_L_OFF = E_ZH + (1 << RAMP_LOG2) + E_SP;
    localparam logic [W-1:0]          GMAX   = {W{1'b1}};
    localparam logic signed [W+1:0]   GMAX_S = $signed({2'b00, GMAX});

    if (PERIOD_CYC < 64 || MAX_STEP < 1) begin : g_bad_param
        $error("fuzzy_speed_ctrl_param: PERIOD_CYC must be >= 64 and MAX_STEP >= 1");
    end

    typedef enum logic [3:0] {
        S_IDLE, S_SAMPLE, S_FUZZ, S_RULE, S_AGG, S_MAC, S_DIV, S_OUT, S_WAIT
    } state_t;

    // Rising ramp grade at distance (mag - off): 0 before the ramp, saturating at GMAX.
    function automatic logic [W-1:0] rise_g(input logic [W-1:0] mag, input int off);
        logic signed [W+2:0] d;
        logic [W+2+S:0]      sh;
        d  = $signed({3'b000, mag}) - $signed((W+3)'(off));
        sh = {{S{1'b0}}, d} << S;
        if (d[W+2] || d == '0) rise_g = '0;
        else if (|sh[W+2+S:W]) rise_g = GMAX;
        else                   rise_g = sh[W-1:0];
    endfunction

    function automatic logic [W-1:0] gmin(input logic [W-1:0] a, input logic [W-1:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [W-1:0] gmax(input logic [W-1:0] a, input logic [W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [W-1:0] centroid(input logic [2:0] idx);
        case (idx)
            3'd0:    return W'(C_STOP);
            3'd1:    return W'(C_SLOW);
            3'd2:    return W'(C_MED);
            3'd3:    return W'(C_FAST);
            default: return W'(C_BLAST);
        endcase
    endfunction

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                first_q, first_d;
    logic signed [W:0]   e_prev_q, e_prev_d, e_q, e_d, de_q, de_d;
    logic [W-1:0]        ge_q [5], ge_d [5];
    logic [W-1:0]        gd_q [3], gd_d [3];
    logic [W-1:0]        rule_q [15], rule_d [15];
    logic [W-1:0]        set_q [5], set_d [5];
    logic [2:0]          ei_q, ei_d, mi_q, mi_d;
    logic [1:0]          di_q, di_d;
    logic [KW-1:0]       kc_q, kc_d;
    logic [NW-1:0]       num_q, num_d;
    logic [DW-1:0]       den_q, den_d, rem_q, rem_d, rem_src;
    logic [W-1:0]        quo_q, quo_d, low_src;
    logic [W-1:0]        pw_q, pw_d;
    logic                done_q, done_d;

    logic signed [W:0]   e_new;
    logic signed [W+1:0] de_diff;
    logic [W-1:0]        ea, da, es, el, dp, rule_new;
    logic [2*W-1:0]      prod;
    logic [DW:0]         trial;
`ifdef FUZZY_SLEW_LIMIT_EN
    localparam logic [W-1:0] STEP_W = W'(MAX_STEP);
    logic [W-1:0]        slew_diff;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = (state_q == S_IDLE) ? cnt_q : cnt_q + CW'(1);
        first_d  = first_q;
        e_prev_d = e_prev_q;
        e_d      = e_q;
        de_d     = de_q;
        ge_d     = ge_q;
        gd_d     = gd_q;
        rule_d   = rule_q;
        set_d    = set_q;
        ei_d     = ei_q;
        di_d     = di_q;
        mi_d     = mi_q;
        kc_d     = kc_q;
        num_d    = num_q;
        den_d    = den_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        pw_d     = pw_q;
        done_d   = 1'b0;
`ifdef FUZZY_SLEW_LIMIT_EN
        slew_diff = '0;
`endif

        e_new   = $signed({1'b0, R}) - $signed({1'b0, C});
        de_diff = $signed({e_new[W], e_new}) - $signed({e_prev_q[W], e_prev_q});
        ea = e_q[W]  ? (~e_q[W-1:0] + W'(1))  : e_q[W-1:0];
        da = de_q[W] ? (~de_q[W-1:0] + W'(1)) : de_q[W-1:0];
        es = gmin(rise_g(ea, E_ZH), ~rise_g(ea, E_L_OFF));
        el = rise_g(ea, E_L_OFF);
        dp = rise_g(da, DE_ZH);
        rule_new = gmin(ge_q[ei_q], gd_q[di_q]);
        prod     = {{W{1'b0}}, set_q[mi_q]} * {{W{1'b0}}, centroid(mi_q)};
        rem_src  = (kc_q == '0) ? num_q[NW-1:W] : rem_q;
        low_src  = (kc_q == '0) ? num_q[W-1:0]  : quo_q;
        trial    = {rem_src, low_src[W-1]};

        case (state_q)
            S_IDLE: if (go) state_d = S_SAMPLE;
            S_SAMPLE: begin
                e_d      = e_new;
                e_prev_d = e_new;
                if (first_q)                de_d = '0;
                else if (de_diff > GMAX_S)  de_d = {1'b0, GMAX};
                else if (de_diff < -GMAX_S) de_d = -$signed({1'b0, GMAX});
                else                        de_d = de_diff[W:0];
                first_d = 1'b0;
                cnt_d   = CW'(1);
                state_d = S_FUZZ;
            end
            S_FUZZ: begin
                ge_d[0] = e_q[W] ? el : '0;
                ge_d[1] = e_q[W] ? es : '0;
                ge_d[2] = ~rise_g(ea, E_ZH);
                ge_d[3] = e_q[W] ? '0 : es;
                ge_d[4] = e_q[W] ? '0 : el;
                gd_d[0] = de_q[W] ? dp : '0;
                gd_d[1] = ~dp;
                gd_d[2] = de_q[W] ? '0 : dp;
                ei_d    = '0;
                di_d    = '0;
                state_d = S_RULE;
            end
            S_RULE: begin
                // Rule k pairs e-set k/3 with de-set k%3; shifting leaves rule k in rule_q[k].
                for (int i = 0; i < 14; i++) rule_d[i] = rule_q[i+1];
                rule_d[14] = rule_new;
                if (di_q == 2'd2) begin
                    di_d = '0;
                    ei_d = ei_q + 3'd1;
                end else begin
                    di_d = di_q + 2'd1;
                end
                if (ei_q == 3'd4 && di_q == 2'd2) state_d = S_AGG;
            end
            S_AGG: begin
                set_d[0] = gmax(gmax(rule_q[0], rule_q[1]), gmax(rule_q[2], rule_q[3]));
                set_d[1] = gmax(gmax(rule_q[4], rule_q[5]), rule_q[6]);
                set_d[2] = rule_q[7];
                set_d[3] = gmax(gmax(rule_q[8], rule_q[9]), rule_q[10]);
                set_d[4] = gmax(gmax(rule_q[11], rule_q[12]), gmax(rule_q[13], rule_q[14]));
                num_d    = '0;
                den_d    = '0;
                mi_d     = '0;
                state_d  = S_MAC;
            end
            S_MAC: begin
                num_d = num_q + {3'b000, prod};
                den_d = den_q + {3'b000, set_q[mi_q]};
                mi_d  = mi_q + 3'd1;
                kc_d  = '0;
                if (mi_q == 3'd4) state_d = S_DIV;
            end
            S_DIV: begin
                // The quotient fits in W bits, so the upper num bits seed the remainder.
                if (trial >= {1'b0, den_q}) begin
                    rem_d = trial[DW-1:0] - den_q;
                    quo_d = {low_src[W-2:0], 1'b1};
                end else begin
                    rem_d = trial[DW-1:0];
                    quo_d = {low_src[W-2:0], 1'b0};
                end
                kc_d = kc_q + KW'(1);
                if (kc_q == KW'(W - 1)) state_d = S_OUT;
            end
            S_OUT: begin
                if (den_q != '0) begin
`ifdef FUZZY_SLEW_LIMIT_EN
                    if (quo_q >= pw_q) begin
                        slew_diff = quo_q - pw_q;
                        pw_d = pw_q + ((slew_diff > STEP_W) ? STEP_W : slew_diff);
                    end else begin
                        slew_diff = pw_q - quo_q;
                        pw_d = pw_q - ((slew_diff > STEP_W) ? STEP_W : slew_diff);
                    end
`else
                    pw_d = quo_q;
`endif
                end
                done_d  = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: if (cnt_q == CW'(PERIOD_CYC - 1)) state_d = go ? S_SAMPLE : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            first_q  <= 1'b1;
            e_prev_q <= '0;
            e_q      <= '0;
            de_q     <= '0;
            for (int i = 0; i < 5; i++) ge_q[i] <= '0;
            for (int i = 0; i < 3; i++) gd_q[i] <= '0;
            for (int i = 0; i < 15; i++) rule_q[i] <= '0;
            for (int i = 0; i < 5; i++) set_q[i] <= '0;
            ei_q     <= '0;
            di_q     <= '0;
            mi_q     <= '0;
            kc_q     <= '0;
            num_q    <= '0;
            den_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            pw_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            first_q  <= first_d;
            e_prev_q <= e_prev_d;
            e_q      <= e_d;
            de_q     <= de_d;
            ge_q     <= ge_d;
            gd_q     <= gd_d;
            rule_q   <= rule_d;
            set_q    <= set_d;
            ei_q     <= ei_d;
            di_q     <= di_d;
            mi_q     <= mi_d;
            kc_q     <= kc_d;
            num_q    <= num_d;
            den_q    <= den_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            pw_q     <= pw_d;
            done_q   <= done_d;
        end
    end

    assign pw   = pw_q;
    assign done = done_q;
    assign busy = (state_q != S_IDLE) && (state_q != S_WAIT);

endmodule

// File: tb/tb_fuzzy_speed_ctrl_param.sv
// Bench for fuzzy_speed_ctrl_param: reference model feeds an expected-pw queue at each sample,
// compared against pw when done pulses; plus directed value, timing and reset checks.
module tb_fuzzy_speed_ctrl_param;
    localparam int W      = 8;
    localparam int PERIOD = 100;
    localparam int LAT    = 24 + W;
    localparam int GM     = (1 << W) - 1;
    localparam int SH     = W - 5;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         go = 1'b0;
    logic [W-1:0] r_in = '0;
    logic [W-1:0] c_in = '0;
    logic [W-1:0] pw;
    logic         busy;
    logic         done;

    fuzzy_speed_ctrl_param #(.W(W), .PERIOD_CYC(PERIOD)) dut (
        .clk(clk), .rst_n(rst_n), .go(go), .R(r_in), .C(c_in),
        .pw(pw), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model state
    int m_eprev = 0;
    bit m_first = 1'b1;
    int m_pw    = 0;

    function automatic int rise(input int d);
        if (d <= 0) return 0;
        if (d * (1 << SH) > GM) return GM;
        return d * (1 << SH);
    endfunction

    function automatic int mn(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int mx(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int model_pw(input int r, input int c);
        int e, de, a, da, z, s, l, nl, ns, ps, pl, dn, dz, dpp;
        int stop, slow, med, fast, blast, num, den, nw, step;
        e  = r - c;
        de = m_first ? 0 : e - m_eprev;
        if (de > GM) de = GM;
        if (de < -GM) de = -GM;
        m_eprev = e;
        m_first = 1'b0;
        a  = (e < 0) ? -e : e;
        da = (de < 0) ? -de : de;
        z  = GM - rise(a - 10);
        s  = mn(rise(a - 10), GM - rise(a - 65));
        l  = rise(a - 65);
        nl = (e < 0) ? l : 0;
        ns = (e < 0) ? s : 0;
        ps = (e > 0) ? s : 0;
        pl = (e > 0) ? l : 0;
        dz  = GM - rise(da - 5);
        dn  = (de < 0) ? rise(da - 5) : 0;
        dpp = (de > 0) ? rise(da - 5) : 0;
        blast = mx(mx(mn(ps, dpp), mn(pl, dn)), mx(mn(pl, dz), mn(pl, dpp)));
        fast  = mx(mx(mn(ps, dz), mn(ps, dn)), mn(z, dpp));
        med   = mn(z, dz);
        slow  = mx(mx(mn(z, dn), mn(ns, dpp)), mn(ns, dz));
        stop  = mx(mx(mn(ns, dn), mn(nl, dn)), mx(mn(nl, dz), mn(nl, dpp)));
        num = stop * 119 + slow * 153 + med * 187 + fast * 221 + blast * 255;
        den = stop + slow + med + fast + blast;
        nw  = (den != 0) ? num / den : m_pw;
`ifdef FUZZY_SLEW_LIMIT_EN
        step = nw - m_pw;
        if (step > 16) step = 16;
        if (step < -16) step = -16;
        m_pw = m_pw + step;
`else
        step = 0;
        m_pw = nw + step;
`endif
        return m_pw;
    endfunction

    // Scoreboard
    logic [W-1:0] exp_q[$];
    int           samp_q[$];
    bit           busy_prev = 1'b0;
    bit           chk_period = 1'b0;
    bit           have_last = 1'b0;
    int           last_done = 0;
    int           n_done = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            samp_q.delete();
            busy_prev = 1'b0;
            have_last = 1'b0;
            m_eprev   = 0;
            m_first   = 1'b1;
            m_pw      = 0;
        end else begin
            if (busy && !busy_prev) begin
                exp_q.push_back(W'(model_pw(int'(r_in), int'(c_in))));
                samp_q.push_back(cyc);
            end
            busy_prev = busy;
            if (done) begin
                n_done++;
                check_eq("done_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    check_eq("pw", int'(pw), int'(exp_q.pop_front()));
                    check_eq("latency", cyc - samp_q.pop_front(), LAT);
                end
                if (chk_period && have_last) check_eq("period", cyc - last_done, PERIOD);
                last_done = cyc;
                have_last = 1'b1;
            end
        end
    end

    // Driver tasks
    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        go    = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_done(input int max_cyc);
        int start = n_done;
        int k = 0;
        while (n_done == start && k < max_cyc) begin
            @(negedge clk); #1;
            k++;
        end
        check_eq("done_seen", n_done - start, 1);
    endtask

    task automatic wait_sample(input int max_cyc);
        int k = 0;
        while (!busy && k < max_cyc) begin
            @(negedge clk); #1;
            k++;
        end
        check_eq("sample_seen", int'(busy), 1);
    endtask

    task automatic fresh_case(input int r, input int c, input int exp_pw);
        do_reset();
        r_in = W'(r);
        c_in = W'(c);
        go   = 1'b1;
        wait_done(LAT + 10);
        check_eq("fresh_pw", int'(pw), exp_pw);
        go = 1'b0;
        repeat (PERIOD + 10) @(posedge clk);
        #1 check_eq("fresh_idle_busy", int'(busy), 0);
    endtask

    int slew_exp [5];
    int base;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_pw", int'(pw), 0);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_done", int'(done), 0);
        rst_n = 1'b1;

        fresh_case(100, 100, 187);
        fresh_case(200, 0, 255);
        fresh_case(0, 200, 119);
        fresh_case(126, 100, 204);

        // Free run with random references; samples must be exactly one period apart
        do_reset();
        chk_period = 1'b1;
        base = n_done;
        go = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #1;
            if ($urandom_range(0, 29) == 0) begin
                r_in = W'($urandom_range(0, GM));
                c_in = W'($urandom_range(0, GM));
            end
        end
        check_eq("run_dones", n_done - base, 10);

        // Drop go during the divide phase
        wait_sample(PERIOD + 10);
        repeat (25) @(posedge clk);
        #1 go = 1'b0;
        wait_done(LAT);
        chk_period = 1'b0;
        repeat (PERIOD) @(posedge clk);
        #1 check_eq("drop_busy", int'(busy), 0);
        base = n_done;
        repeat (200) @(posedge clk);
        #1;
        check_eq("drop_no_more_done", n_done - base, 0);
        check_eq("drop_pw_held", int'(pw), m_pw);
        check_eq("drop_idle_busy", int'(busy), 0);

        // Async reset during the divide phase, then first sample must use de = 0
        do_reset();
        r_in = W'(50);
        c_in = W'(150);
        go = 1'b1;
        wait_done(LAT + 10);
        r_in = W'(126);
        c_in = W'(100);
        wait_sample(PERIOD + 10);
        repeat (25) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_eq("mid_rst_pw", int'(pw), 0);
        check_eq("mid_rst_busy", int'(busy), 0);
        check_eq("mid_rst_done", int'(done), 0);
        go = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        go = 1'b1;
        wait_done(LAT + 10);
        check_eq("post_rst_de0_pw", int'(pw), 204);
        go = 1'b0;
        repeat (PERIOD + 10) @(posedge clk);

        // Steady 187, then a full-scale step
`ifdef FUZZY_SLEW_LIMIT_EN
        slew_exp = '{203, 219, 235, 251, 255};
`else
        slew_exp = '{255, 255, 255, 255, 255};
`endif
        do_reset();
        r_in = W'(100);
        c_in = W'(100);
        go = 1'b1;
        wait_done(LAT + 10);
        check_eq("steady_pw", int'(pw), 187);
        wait_done(PERIOD + 10);
        check_eq("steady_pw2", int'(pw), 187);
        r_in = W'(200);
        c_in = W'(0);
        for (int i = 0; i < 5; i++) begin
            wait_done(PERIOD + 10);
            check_eq($sformatf("step_pw%0d", i), int'(pw), slew_exp[i]);
        end
        go = 1'b0;
        repeat (PERIOD + 10) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fuzzy_speed_ctrl_param.md
Name: fuzzy_speed_ctrl_param

Overview:
Parametrised successor to the team's 8-bit fuzzy-logic motor speed controller. It samples reference R and measured speed C once per programmable period. It fuzzifies the error and the change in error, evaluates 15 min-rules, aggregates them into 5 output sets, and computes the centroid with an iterative divider. The block drives pw to the PWM stage and adds a busy/done handshake, a first-sample guard and optional slew limiting.

Parameters:
W, 8, data width of R, C and pw; grade maximum GMAX = 2^W-1
PERIOD_CYC, 25000000, clocks between successive samples while go is high; minimum 64
RAMP_LOG2, 5, log2 of every ramp width; slope shift S = W-RAMP_LOG2
E_ZH, 10, half-width of error Z plateau
E_SP, 23, width of error NS/PS plateau
DE_ZH, 5, half-width of de Z plateau
C_STOP/C_SLOW/C_MED/C_FAST/C_BLAST, 119/153/187/221/255, output-set centroids (W bits)
MAX_STEP, 16, largest pw change per update; used only with FUZZY_SLEW_LIMIT_EN

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous, active-low reset
go  in  1  level enable; controller runs while high
R  in  W  reference speed, unsigned
C  in  W  measured speed, unsigned
pw  out  W  pulse-width command, registered
busy  out  1  high from SAMPLE through OUT
done  out  1  one-cycle pulse when pw updates

Behaviour:
- Reset (async, rst_n=0): pw=0, busy=0, done=0, state=IDLE, period counter=0, e_prev=0, first=1. Takes effect mid-operation with no completion.
- Error arithmetic:
  - e = R-C, signed W+1 bits.
  - de = e-e_prev, signed, saturated to ±GMAX.
  - On the first sample after reset, de is forced to 0.
- Error membership. Distance into a ramp is d; rising grade = min(GMAX, d<<S); falling grade = GMAX - rising.
  - Z: plateau |e|<=E_ZH.
  - NS/PS: ramps of 2^RAMP_LOG2 meet the Z ramps, then plateau of width E_SP, then fall.
  - NL/PL: saturate to GMAX beyond their ramps.
- de membership: N, Z, P built the same way around plateau |de|<=DE_ZH.
- Rule aggregation (max of min):
  - BLAST = PS&P, PL&N, PL&Z, PL&P
  - FAST = PS&Z, PS&N, Z&P
  - MED = Z&Z
  - SLOW = Z&N, NS&P, NS&Z
  - STOP = NS&N, NL&N, NL&Z, NL&P
- Defuzzification:
  - num = sum(g_i*C_i), 2W+3 bits; den = sum(g_i), W+3 bits.
  - pw_new = floor(num/den), W bits.
  - If den=0, pw holds its previous value.
- State machine:
  - IDLE -> SAMPLE when go=1.
  - SAMPLE (1 cycle): latch R, C, compute e/de, e_prev<=e, clear first, restart period counter.
  - FUZZ (1 cycle): register 8 grades.
  - RULE (15 cycles, one min per cycle, counter 0..14).
  - AGG (1 cycle).
  - MAC (5 cycles, one set per cycle).
  - DIV (W cycles, restoring, 1 quotient bit per cycle).
  - OUT (1 cycle): pw<=result, done=1.
  - WAIT: count to PERIOD_CYC measured from SAMPLE; then SAMPLE if go=1, else IDLE.
- Latency and timing:
  - SAMPLE to done = 24+W cycles (32 at W=8).
  - Samples are exactly PERIOD_CYC apart while go stays high.
- go deasserted mid-computation: the computation completes, pw updates, done pulses, then the block returns to IDLE. pw holds in IDLE.
- R/C changes after SAMPLE are ignored until the next sample.

Optional Feature:
FUZZY_SLEW_LIMIT_EN
- Defined: in OUT, pw moves toward pw_new by at most MAX_STEP per update, i.e. pw <= pw ± min(|pw_new-pw|, MAX_STEP).
- Undefined: pw <= pw_new directly; MAX_STEP is unused; no extra logic.

Test Plan:
- Reset, then R=100, C=100, go=1 -> first done 32 cycles after SAMPLE, de=0, MED=255 only, pw=187.
- After reset, R=200, C=0 -> e=200, PL=255, de forced 0 -> pw=255; R=0, C=200 after reset -> NL, pw=119.
- After reset, R=126, C=100 (e=26, de=0) -> Z=127, PS=128, num=52037, den=255 -> pw=204 (truncated).
- PERIOD_CYC=100, go held high 1000 cycles -> done pulses exactly 100 cycles apart; drop go mid-DIV -> one more done, then busy=0, pw held.
- Assert rst_n low during DIV -> pw=0, busy=0, done=0 immediately without a clock edge; next sample after release uses de=0.
- With FUZZY_SLEW_LIMIT_EN, MAX_STEP=16: steady pw=187, then R=200, C=0 -> successive pw 203, 219, 235, 251, 255.
